dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one data-memory port between the instruction-fetch unit (read-only) and the LSU (read/write).
- Grants one requester per cycle and forwards its request to memory combinationally.
- Allows one outstanding read and routes the read response back to the requester that issued it.
- Sits between the fetch/LSU stages and the single-port memory macro.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; must be 32 (4 byte strobes).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- if_req  input  1  fetch read request; held with if_addr until if_gnt
- if_addr  input  ADDR_W  fetch address (word aligned)
- if_gnt  output  1  fetch request accepted this cycle
- if_rdata  output  DATA_W  fetch read data, valid with if_rvld
- if_rvld  output  1  fetch read response
- ls_req  input  1  LSU request; held with ls_wen, ls_addr, ls_wdata until ls_gnt
- ls_wen  input  4  byte write enables; 0 means read
- ls_addr  input  ADDR_W  LSU address
- ls_wdata  input  DATA_W  LSU write data, already lane-aligned
- ls_gnt  output  1  LSU request accepted this cycle
- ls_rdata  output  DATA_W  LSU read data, valid with ls_rvld
- ls_rvld  output  1  LSU read response
- mem_en  output  1  memory request strobe
- mem_wen  output  4  memory byte write enables
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_rvld  input  1  memory read response, latency ≥1 cycle
- arb_busy  output  1  a read is outstanding

Behaviour:
- Reset state: state=IDLE, prio=LS. While RST=1, every output is 0.
- States:
  - IDLE: no outstanding read.
  - RD_IF: fetch read outstanding.
  - RD_LS: LSU read outstanding.
- accept = (state==IDLE) | mem_rvld. A grant may occur in the same cycle a response returns, giving back-to-back reads.
- Grant rules, evaluated only when accept=1:
  - One requester: that requester is granted.
  - Both requesting: the requester selected by the arbitration policy is granted.
  - At most one gnt per cycle. gnt is never asserted without the matching req.
- Granted cycle:
  - mem_en=1.
  - mem_addr, mem_wen and mem_wdata are the granted requester's signals, combinational, zero added latency.
  - Fetch grant forces mem_wen=0 and mem_wdata=0.
- Ungranted cycle: mem_en, mem_wen, mem_addr and mem_wdata are all 0.
- Next state:
  - Fetch grant → RD_IF.
  - LSU grant with ls_wen==0 → RD_LS.
  - LSU grant with ls_wen!=0 (write) → IDLE. Writes complete in the grant cycle and return no response.
  - No grant while mem_rvld=1 → IDLE.
  - Otherwise, hold state.
- Response routing:
  - RD_IF & mem_rvld → if_rvld=1, if_rdata=mem_rdata.
  - RD_LS & mem_rvld → ls_rvld=1, ls_rdata=mem_rdata.
  - Non-selected rdata outputs are 0.
- mem_rvld in IDLE (spurious, or late after reset) is dropped. No rvld output fires.
- arb_busy = (state!=IDLE).
- A requester that drops req before its grant is legal; nothing is issued for it.
- Reset mid-read: state returns to IDLE and the pending response is discarded. The requester re-issues its request after reset.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - 1-bit prio register names the requester that wins on contention.
  - After any grant, prio flips to the other requester. It updates only on grant cycles.
  - Reset value is LS.
- Undefined: fixed priority, LSU always wins on contention. The prio register is absent.

Test Plan:
- Single fetch read: if_req=1, if_addr=0x100, memory responds 2 cycles later with 0xDEADBEEF → if_gnt in cycle 0; mem_en=1, mem_addr=0x100, mem_wen=0; arb_busy=1 for 2 cycles; if_rvld=1 with if_rdata=0xDEADBEEF; ls_rvld stays 0.
- LSU byte store: ls_req=1, ls_wen=4'b0100, ls_addr=0x202, ls_wdata=0x00AB0000 → ls_gnt the same cycle; mem_wen=4'b0100, mem_wdata=0x00AB0000; state stays IDLE; a new fetch request is granted the next cycle.
- Contention, fixed priority (macro undefined): both req from IDLE, LSU read at 0x40 → ls_gnt first; if_gnt in the mem_rvld cycle of the LSU read; ls_rvld then if_rvld, each with the correct data.
- Contention, round-robin (macro defined): both requests held continuously for 4 grants, reads with 1-cycle latency → grant order LS, IF, LS, IF; each grant coincides with the previous mem_rvld.
- Spurious/late response: assert RST during RD_LS, release it, then pulse mem_rvld with 0x12345678 → no ls_rvld or if_rvld; state stays IDLE; all outputs were 0 during reset.
- Held request: ls_req=1 read while a fetch read is outstanding for 3 cycles → ls_gnt=0 and mem_en=0 for 2 cycles; ls_gnt=1 on the mem_rvld cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals of dmem_arbiter.
// The arbiter connects through the "slave" modport: it receives requests
// from fetch/LSU and returns read data to them, and it drives the memory
// request lines. The "master" modport is the view of the surrounding logic
// (fetch unit, LSU and memory macro together).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvld;
  // LSU port
  logic              ls_req;
  logic [3:0]        ls_wen;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_rvld;
  // Memory port
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvld;
  // Status
  logic              arb_busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rdata, if_rvld,
    input  ls_req, ls_wen, ls_addr, ls_wdata,
    output ls_gnt, ls_rdata, ls_rvld,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvld,
    output arb_busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rdata, if_rvld,
    output ls_req, ls_wen, ls_addr, ls_wdata,
    input  ls_gnt, ls_rdata, ls_rvld,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_rvld,
    input  arb_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between instruction fetch
// (read-only) and the LSU (read/write). One grant per cycle, request is
// forwarded to memory combinationally, one read may be outstanding and its
// response is routed back to the requester that issued it.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise the LSU always wins (fixed priority).
//
// Handshake: a requester raises req and holds req together with its
// address/controls until it sees gnt in the same cycle; gnt is the single
// acceptance event (req & gnt = transfer). A requester may drop req before
// gnt, in which case nothing is issued. Read data comes back later as a
// one-cycle rvld pulse with rdata; writes return nothing.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32  // four byte lanes, so this stays 32
) (
  input  logic        CLK,
  input  logic        RST,
  dmem_arbiter_if.slave bus,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic gnt_if;
  logic gnt_ls;
  logic ls_wins;

  logic [3:0]        fwd_wen;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_wdata;

`ifdef DMEM_ARB_RR_EN
  localparam logic PRIO_LS = 1'b0;

  logic prio;

  // Round-robin pointer: toggles on every grant, so the other side wins next contention.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio <= PRIO_LS;
    end else if (gnt_if || gnt_ls) begin
      prio <= ~prio;
    end
  end

  assign ls_wins = (prio == PRIO_LS);
`else
  // Fixed priority: the LSU always wins when both sides request.
  assign ls_wins = 1'b1;
`endif

  // Grant decision: only when no read is pending or the pending one returns now.
  always_comb begin
    accept = (state == IDLE) || bus.mem_rvld;
    gnt_if = accept && bus.if_req && (!bus.ls_req || !ls_wins);
    gnt_ls = accept && bus.ls_req && !gnt_if;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: track which requester owns the outstanding read.
  always_comb begin
    state_nxt = state;
    if (gnt_if) begin
      state_nxt = RD_IF;
    end else if (gnt_ls) begin
      // A write finishes in its grant cycle; only a read leaves something pending.
      state_nxt = (bus.ls_wen == 4'b0000) ? RD_LS : IDLE;
    end else if (bus.mem_rvld) begin
      state_nxt = IDLE;
    end
  end

  // Request mux: forward the granted requester to memory; fetch never writes.
  always_comb begin
    fwd_wen   = 4'b0000;
    fwd_addr  = '0;
    fwd_wdata = '0;
    if (gnt_if) begin
      fwd_addr = bus.if_addr;
    end else if (gnt_ls) begin
      fwd_wen   = bus.ls_wen;
      fwd_addr  = bus.ls_addr;
      fwd_wdata = bus.ls_wdata;
    end
  end

  // Outputs: everything held at zero while RST is high; responses routed by state,
  // so a response arriving in IDLE (spurious, or after a reset) is dropped.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wen   = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_rvld   = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvld   = 1'b0;
    bus.ls_rdata  = '0;
    bus.arb_busy  = 1'b0;
    fsm_state     = 2'b00;
    if (!RST) begin
      bus.if_gnt    = gnt_if;
      bus.ls_gnt    = gnt_ls;
      bus.mem_en    = gnt_if || gnt_ls;
      bus.mem_wen   = fwd_wen;
      bus.mem_addr  = fwd_addr;
      bus.mem_wdata = fwd_wdata;
      if ((state == RD_IF) && bus.mem_rvld) begin
        bus.if_rvld  = 1'b1;
        bus.if_rdata = bus.mem_rdata;
      end
      if ((state == RD_LS) && bus.mem_rvld) begin
        bus.ls_rvld  = 1'b1;
        bus.ls_rdata = bus.mem_rdata;
      end
      bus.arb_busy = (state != IDLE);
      fsm_state    = state;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of per-cycle vectors
// (inputs plus hand-computed outputs) followed by hand-written sequences for
// reset-during-read, contention and back-to-back grants. Works with or
// without DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic CLK;
  logic RST;
  logic [1:0] fsm_state;

  int n_pass;
  int n_total;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [3:0]  ls_wen;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvld;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_mem_en;
    logic [3:0]  e_mem_wen;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_rvld;
    logic [31:0] e_if_rdata;
    logic        e_ls_rvld;
    logic [31:0] e_ls_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] rst, input logic [31:0] ifr, input logic [31:0] ifa,
    input logic [31:0] lsr, input logic [31:0] lsw, input logic [31:0] lsa,
    input logic [31:0] lswd, input logic [31:0] mrd, input logic [31:0] mrv,
    input logic [31:0] eig, input logic [31:0] elg, input logic [31:0] een,
    input logic [31:0] ewen, input logic [31:0] eaddr, input logic [31:0] ewd,
    input logic [31:0] eirv, input logic [31:0] eird, input logic [31:0] elrv,
    input logic [31:0] elrd, input logic [31:0] ebusy);
    vec_t v;
    v.rst = rst[0]; v.if_req = ifr[0]; v.if_addr = ifa;
    v.ls_req = lsr[0]; v.ls_wen = lsw[3:0]; v.ls_addr = lsa; v.ls_wdata = lswd;
    v.mem_rdata = mrd; v.mem_rvld = mrv[0];
    v.e_if_gnt = eig[0]; v.e_ls_gnt = elg[0]; v.e_mem_en = een[0];
    v.e_mem_wen = ewen[3:0]; v.e_mem_addr = eaddr; v.e_mem_wdata = ewd;
    v.e_if_rvld = eirv[0]; v.e_if_rdata = eird; v.e_ls_rvld = elrv[0];
    v.e_ls_rdata = elrd; v.e_busy = ebusy[0];
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Driver: set all requester/memory inputs at once
  task automatic drive(
    input logic [31:0] ifr, input logic [31:0] ifa, input logic [31:0] lsr,
    input logic [31:0] lsw, input logic [31:0] lsa, input logic [31:0] lswd,
    input logic [31:0] mrd, input logic [31:0] mrv);
    bus.if_req    = ifr[0];
    bus.if_addr   = ifa;
    bus.ls_req    = lsr[0];
    bus.ls_wen    = lsw[3:0];
    bus.ls_addr   = lsa;
    bus.ls_wdata  = lswd;
    bus.mem_rdata = mrd;
    bus.mem_rvld  = mrv[0];
  endtask

  // Driver: one reset cycle, returns just after a falling edge with RST low
  task automatic reset_cycle();
    @(negedge CLK);
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [11:0] outs;
  logic        exp_is_if[4];
  logic        last_is_if;

  initial begin
    n_pass  = 0;
    n_total = 0;
    RST     = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // rst ifr ifa lsr lsw lsa lswd mrd mrv | if_gnt ls_gnt en wen addr wdata if_rvld if_rdata ls_rvld ls_rdata busy
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // single fetch read, response two cycles after the grant
    vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0, 0, 0,             1, 0, 1, 0, 'h100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 1,        0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // LSU byte store, then a fetch is granted the very next cycle
    vecs.push_back(mk(0, 0, 0, 1, 'h4, 'h202, 'h00AB0000, 0, 0,  0, 1, 1, 'h4, 'h202, 'h00AB0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h104, 0, 0, 0, 0, 0, 0,             1, 0, 1, 0, 'h104, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h11111111, 1,        0, 0, 0, 0, 0, 0, 1, 'h11111111, 0, 0, 1));
    // LSU read held while a fetch read is outstanding for three cycles
    vecs.push_back(mk(0, 1, 'h108, 0, 0, 0, 0, 0, 0,             1, 0, 1, 0, 'h108, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h300, 'hFFFFFFFF, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h300, 'hFFFFFFFF, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h300, 'hFFFFFFFF, 'h22222222, 1, 0, 1, 1, 0, 'h300, 'hFFFFFFFF, 1, 'h22222222, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h33333333, 1,        0, 0, 0, 0, 0, 0, 0, 0, 1, 'h33333333, 1));
    // spurious response in IDLE is dropped
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h44444444, 1,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fetch grant ignores stray LSU write lanes/data (ls_req low)
    vecs.push_back(mk(0, 1, 'h10C, 0, 'hF, 'h999, 'hCAFEF00D, 0, 0, 1, 0, 1, 0, 'h10C, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h55555555, 1,        0, 0, 0, 0, 0, 0, 1, 'h55555555, 0, 0, 1));
    // LSU request dropped before its grant: nothing issued for it
    vecs.push_back(mk(0, 1, 'h110, 0, 0, 0, 0, 0, 0,             1, 0, 1, 0, 'h110, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h400, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h66666666, 1,        0, 0, 0, 0, 0, 0, 1, 'h66666666, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge CLK);
      RST = vecs[i].rst;
      drive(32'(vecs[i].if_req), vecs[i].if_addr, 32'(vecs[i].ls_req), 32'(vecs[i].ls_wen),
            vecs[i].ls_addr, vecs[i].ls_wdata, vecs[i].mem_rdata, 32'(vecs[i].mem_rvld));
      #1;
      chk($sformatf("v%0d_if_gnt", i),    32'(bus.if_gnt),   32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d_ls_gnt", i),    32'(bus.ls_gnt),   32'(vecs[i].e_ls_gnt));
      chk($sformatf("v%0d_mem_en", i),    32'(bus.mem_en),   32'(vecs[i].e_mem_en));
      chk($sformatf("v%0d_mem_wen", i),   32'(bus.mem_wen),  32'(vecs[i].e_mem_wen));
      chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr,      vecs[i].e_mem_addr);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata,     vecs[i].e_mem_wdata);
      chk($sformatf("v%0d_if_rvld", i),   32'(bus.if_rvld),  32'(vecs[i].e_if_rvld));
      chk($sformatf("v%0d_if_rdata", i),  bus.if_rdata,      vecs[i].e_if_rdata);
      chk($sformatf("v%0d_ls_rvld", i),   32'(bus.ls_rvld),  32'(vecs[i].e_ls_rvld));
      chk($sformatf("v%0d_ls_rdata", i),  bus.ls_rdata,      vecs[i].e_ls_rdata);
      chk($sformatf("v%0d_arb_busy", i),  32'(bus.arb_busy), 32'(vecs[i].e_busy));
    end

    // Reset in the middle of an LSU read; late response afterwards is dropped
    reset_cycle();
    @(negedge CLK);
    drive(0, 0, 1, 0, 'h500, 0, 0, 0);
    #1;
    chk("rst_mid_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_state_rd_ls", 32'(fsm_state), 32'd2);
    @(negedge CLK);
    RST = 1'b1;
    drive(1, 'h700, 1, 0, 'h500, 'h77, 'h12345678, 1);
    #1;
    outs = {bus.if_gnt, bus.ls_gnt, bus.mem_en, |bus.mem_wen, |bus.mem_addr, |bus.mem_wdata,
            bus.if_rvld, |bus.if_rdata, bus.ls_rvld, |bus.ls_rdata, bus.arb_busy, |fsm_state};
    chk("rst_all_outputs_zero", 32'(outs), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 'h12345678, 1);
    #1;
    chk("late_rvld_if_rvld", 32'(bus.if_rvld), 32'd0);
    chk("late_rvld_ls_rvld", 32'(bus.ls_rvld), 32'd0);
    chk("late_rvld_ls_rdata", bus.ls_rdata, 32'd0);
    chk("late_rvld_busy", 32'(bus.arb_busy), 32'd0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("late_rvld_state_idle", 32'(fsm_state), 32'd0);

    // Contention from IDLE: LSU read at 0x40 wins first, fetch granted on its rvld
    reset_cycle();
    @(negedge CLK);
    drive(1, 'h200, 1, 0, 'h40, 0, 0, 0);
    #1;
    chk("cont_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    chk("cont_if_gnt_blocked", 32'(bus.if_gnt), 32'd0);
    chk("cont_addr_ls", bus.mem_addr, 32'h40);
    @(negedge CLK);
    drive(1, 'h200, 0, 0, 0, 0, 'hA5A5A5A5, 1);
    #1;
    chk("cont_ls_rvld", 32'(bus.ls_rvld), 32'd1);
    chk("cont_ls_rdata", bus.ls_rdata, 32'hA5A5A5A5);
    chk("cont_if_gnt_on_rvld", 32'(bus.if_gnt), 32'd1);
    chk("cont_addr_if", bus.mem_addr, 32'h200);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 'h5A5A5A5A, 1);
    #1;
    chk("cont_if_rvld", 32'(bus.if_rvld), 32'd1);
    chk("cont_if_rdata", bus.if_rdata, 32'h5A5A5A5A);
    chk("cont_ls_rvld_quiet", 32'(bus.ls_rvld), 32'd0);

    // Both requests held for four grants with 1-cycle read latency
`ifdef DMEM_ARB_RR_EN
    exp_is_if[0] = 1'b0; exp_is_if[1] = 1'b1; exp_is_if[2] = 1'b0; exp_is_if[3] = 1'b1;
`else
    exp_is_if[0] = 1'b0; exp_is_if[1] = 1'b0; exp_is_if[2] = 1'b0; exp_is_if[3] = 1'b0;
`endif
    reset_cycle();
    last_is_if = 1'b0;
    for (int g = 0; g < 4; g++) begin
      @(negedge CLK);
      drive(1, 'h700, 1, 0, 'h600, 0, 32'h1000 + 32'(g), (g > 0) ? 1 : 0);
      #1;
      chk($sformatf("b2b%0d_if_gnt", g), 32'(bus.if_gnt), 32'(exp_is_if[g]));
      chk($sformatf("b2b%0d_ls_gnt", g), 32'(bus.ls_gnt), 32'(!exp_is_if[g]));
      chk($sformatf("b2b%0d_addr", g), bus.mem_addr, exp_is_if[g] ? 32'h700 : 32'h600);
      if (g > 0) begin
        chk($sformatf("b2b%0d_if_rvld", g), 32'(bus.if_rvld), 32'(last_is_if));
        chk($sformatf("b2b%0d_ls_rvld", g), 32'(bus.ls_rvld), 32'(!last_is_if));
      end
      last_is_if = exp_is_if[g];
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 'h2000, 1);
    #1;
    chk("b2b_tail_if_rvld", 32'(bus.if_rvld), 32'(last_is_if));
    chk("b2b_tail_ls_rvld", 32'(bus.ls_rvld), 32'(!last_is_if));
    chk("b2b_tail_rdata", last_is_if ? bus.if_rdata : bus.ls_rdata, 32'h2000);
    chk("b2b_tail_no_gnt", 32'(bus.mem_en), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
